cpu_bus_interface: RTL and testbench
====================================

// Module: cpu_bus_interface
// PURPOSE
//  Two-channel bus master between the multicycle CPU core and the system bus. It arbitrates
//  instruction-fetch (IF) and load/store (LS) requests onto one bus. It generates
//  bhw/byte-lane-replicated store data and returns aligned, sign/zero-extended load data.
//  It checks alignment and, optionally, bus timeout. Successor to the fixed single-path
//  memory controller; data width is 32 (RV32).
// PARAMETERS
//  ADDR_W          32    bus/request address width
//  TIMEOUT_CYCLES  1023  WAIT-state cycles before timeout error (only with CPU_BIU_TIMEOUT_EN)
//  FIRST_PRIO      0     channel that wins the first simultaneous request after reset: 0=LS, 1=IF
// PORTS
//  i_clk           in   1       clock, all logic on rising edge
//  i_rst_n         in   1       asynchronous active-low reset
//  i_if_req        in   1       fetch request (sampled when o_if_ready=1)
//  i_if_addr       in   ADDR_W  fetch address
//  o_if_ready      out  1       IF request accepted this cycle
//  o_if_valid      out  1       1-cycle pulse: o_if_data/o_if_err valid
//  o_if_data       out  32      fetched word
//  o_if_err        out  1       misaligned or timeout, qualified by o_if_valid
//  i_ls_req        in   1       load/store request
//  i_ls_we         in   1       1=store, 0=load
//  i_ls_funct3     in   3       RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_ls_addr       in   ADDR_W  byte address
//  i_ls_wdata      in   32      store data (LSBs significant)
//  o_ls_ready      out  1       LS request accepted this cycle
//  o_ls_valid      out  1       1-cycle pulse: o_ls_rdata/o_ls_err valid
//  o_ls_rdata      out  32      extended load data; 0 for stores
//  o_ls_err        out  1       misaligned, illegal funct3 or timeout
//  i_bus_data      in   32      bus read data
//  i_bus_DV        in   1       bus response/ack strobe
//  o_bus_data      out  32      bus write data, lane-replicated
//  o_bus_address   out  ADDR_W  bus address
//  o_bus_DV        out  1       1-cycle bus request strobe
//  o_bhw           out  3       access size = funct3 (IF always 010)
//  o_write_notread out  1       1=write
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, priority pointer=FIRST_PRIO. Effective immediately (async).
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: o_*_ready = 1 for the granted pending channel only.
//   - One request: it is granted.
//   - Both requesting: the pointer channel wins; the pointer then flips to the loser (round-robin).
//   - Request captured in registers; go to REQ. If the request fails checks, go to RESP with err=1 instead.
//  Checks: H/HU need addr[0]=0; W and IF need addr[1:0]=0; other funct3 values are illegal.
//   - Error: no bus cycle issued; response err=1, data=0, valid at accept+1.
//  REQ: o_bus_DV=1 for exactly one cycle. o_bus_address/o_bhw/o_write_notread/o_bus_data are
//   held from REQ until leaving WAIT. Store data: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
//  WAIT: on i_bus_DV=1 register i_bus_data, go to RESP. i_bus_DV in REQ cycle is legal (accepted).
//  RESP: the owning channel's o_*_valid=1 for one cycle.
//   - Load data selects the lane by addr[1:0] (byte) or addr[1] (half) and extends:
//     B/H sign-extend, BU/HU zero-extend. Store rdata=0.
//   - IF returns the raw word.
//  Latency: accept cycle n -> o_bus_DV at n+1 -> i_bus_DV at m>=n+1 -> o_*_valid at m+1.
//   New accept no earlier than m+2 (one outstanding transaction).
//  i_bus_DV outside REQ/WAIT is ignored. Requests dropped before accept are never issued.
//  Reset mid-transaction abandons it: no valid pulse, the late i_bus_DV is ignored.
// CONFIGURATION
//  CPU_BIU_TIMEOUT_EN defined: counter starts at REQ.
//   - TIMEOUT_CYCLES WAIT cycles without i_bus_DV -> RESP with err=1, data=0.
//   - A late i_bus_DV is ignored.
//  Undefined: no counter; WAIT holds until i_bus_DV; *_err only from checks.
// TESTING
//  1 IF 0x100, bus replies 0xDEADBEEF after 3 cycles -> o_bus_DV 1 pulse, bhw=010, o_if_data=0xDEADBEEF, err=0.
//  2 LS load funct3=000 addr 0x203, bus 0x80FF_0000 -> o_ls_rdata=0xFFFFFF80; funct3=100 -> 0x00000080.
//  3 Store funct3=001 addr 0x12 wdata 0x1234ABCD -> o_bus_data=0xABCDABCD, bhw=001, wnr=1, rdata=0.
//  4 IF+LS same cycle from reset (FIRST_PRIO=0) -> LS first, then IF; next collision IF first.
//  5 LW addr 0x6 -> no o_bus_DV, o_ls_valid+o_ls_err at accept+1; i_rst_n low in WAIT -> no valid.
//  6 CPU_BIU_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus silent -> err=1 after 8 WAIT cycles; late DV ignored.

Source files
------------

// File: rtl/cpu_bus_interface_if.sv
// cpu_bus_interface_if: groups the CPU-side IF/LS request channels and the system bus.
//  master : view used by cpu_bus_interface (drives o_*, samples i_*)
//  slave  : view used by the core/bus environment (drives i_*, samples o_*)
//  IF channel : i_if_req, i_if_addr -> o_if_ready, o_if_valid, o_if_data, o_if_err
//  LS channel : i_ls_req, i_ls_we, i_ls_funct3, i_ls_addr, i_ls_wdata
//               -> o_ls_ready, o_ls_valid, o_ls_rdata, o_ls_err
//  System bus : i_bus_data, i_bus_DV -> o_bus_data, o_bus_address, o_bus_DV, o_bhw, o_write_notread
interface cpu_bus_interface_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_ready;
    logic              o_if_valid;
    logic [31:0]       o_if_data;
    logic              o_if_err;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [2:0]        i_ls_funct3;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [31:0]       i_ls_wdata;
    logic              o_ls_ready;
    logic              o_ls_valid;
    logic [31:0]       o_ls_rdata;
    logic              o_ls_err;

    logic [31:0]       i_bus_data;
    logic              i_bus_DV;
    logic [31:0]       o_bus_data;
    logic [ADDR_W-1:0] o_bus_address;
    logic              o_bus_DV;
    logic [2:0]        o_bhw;
    logic              o_write_notread;

    modport master (
        input  i_if_req, i_if_addr,
        output o_if_ready, o_if_valid, o_if_data, o_if_err,
        input  i_ls_req, i_ls_we, i_ls_funct3, i_ls_addr, i_ls_wdata,
        output o_ls_ready, o_ls_valid, o_ls_rdata, o_ls_err,
        input  i_bus_data, i_bus_DV,
        output o_bus_data, o_bus_address, o_bus_DV, o_bhw, o_write_notread
    );

    modport slave (
        output i_if_req, i_if_addr,
        input  o_if_ready, o_if_valid, o_if_data, o_if_err,
        output i_ls_req, i_ls_we, i_ls_funct3, i_ls_addr, i_ls_wdata,
        input  o_ls_ready, o_ls_valid, o_ls_rdata, o_ls_err,
        output i_bus_data, i_bus_DV,
        input  o_bus_data, o_bus_address, o_bus_DV, o_bhw, o_write_notread
    );
endinterface

// File: rtl/cpu_bus_interface.sv
// cpu_bus_interface: two-channel (instruction fetch / load-store) bus master for the RV32 core.
//  Arbitrates IF and LS round-robin onto one bus, one transaction outstanding at a time,
//  replicates store data across byte lanes and returns aligned, extended load data.
//  Ports : i_clk, i_rst_n (async active-low), bus (cpu_bus_interface_if.master).
//  Params: ADDR_W, TIMEOUT_CYCLES, FIRST_PRIO (0 = LS wins first collision, 1 = IF).
//  Option: define CPU_BIU_TIMEOUT_EN to end a silent bus cycle with err after
//          TIMEOUT_CYCLES WAIT cycles; otherwise WAIT holds until i_bus_DV.
module cpu_bus_interface #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned FIRST_PRIO     = 0
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    cpu_bus_interface_if.master bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef CPU_BIU_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Alignment and funct3 legality; IF is always a word access.
    function automatic logic access_ok(input logic is_if, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        if (is_if) begin
            ok = (a == 2'b00);
        end else begin
            case (f3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = ~a[0];
                F3_W:        ok = (a == 2'b00);
                default:     ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Replicate the significant store bytes onto every lane they may land on.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3, input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        case (f3[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Pick the addressed lane and sign/zero-extend it.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                      input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] sh;
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;        // 1 = IF wins the next collision
    logic              owner_q, owner_d;    // 1 = transaction belongs to IF
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        bhw_q, bhw_d;
    logic              wnr_q, wnr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bus_dv_q, bus_dv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              if_err_q, if_err_d;
    logic              ls_valid_q, ls_valid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_err_q, ls_err_d;

    logic              if_ready_c, ls_ready_c;
    logic              grant_if, grant_ls;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic              resp_fire, resp_err;
    logic [DATA_W-1:0] resp_data;

    // Next-state, arbitration and response formation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        bhw_d      = bhw_q;
        wnr_d      = wnr_q;
        wdata_d    = wdata_q;
        bus_dv_d   = 1'b0;
        cnt_d      = cnt_q;
        if_valid_d = 1'b0;
        if_data_d  = if_data_q;
        if_err_d   = if_err_q;
        ls_valid_d = 1'b0;
        ls_rdata_d = ls_rdata_q;
        ls_err_d   = ls_err_q;
        if_ready_c = 1'b0;
        ls_ready_c = 1'b0;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        req_f3     = F3_W;
        req_addr   = '0;
        req_we     = 1'b0;
        resp_fire  = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;

        case (state_q)
            ST_IDLE: begin
                grant_if   = bus.i_if_req & (~bus.i_ls_req | ptr_q);
                grant_ls   = bus.i_ls_req & ~grant_if;
                if_ready_c = grant_if & i_rst_n;
                ls_ready_c = grant_ls & i_rst_n;
                req_f3     = grant_if ? F3_W : bus.i_ls_funct3;
                req_addr   = grant_if ? bus.i_if_addr : bus.i_ls_addr;
                req_we     = grant_ls & bus.i_ls_we;
                if (grant_if | grant_ls) begin
                    owner_d = grant_if;
                    // Only a collision moves the pointer: it goes to the loser.
                    if (bus.i_if_req & bus.i_ls_req) begin
                        ptr_d = grant_ls;
                    end
                    if (access_ok(grant_if, req_f3, req_addr[1:0])) begin
                        state_d  = ST_REQ;
                        bus_dv_d = 1'b1;
                        addr_d   = req_addr;
                        bhw_d    = req_f3;
                        wnr_d    = req_we;
                        wdata_d  = req_we ? store_lanes(req_f3, bus.i_ls_wdata) : '0;
                        cnt_d    = '0;
                    end else begin
                        // Rejected access: no bus cycle, error response next cycle.
                        state_d   = ST_RESP;
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (bus.i_bus_DV) begin
                    state_d   = ST_RESP;
                    resp_fire = 1'b1;
                    if (owner_q) begin
                        resp_data = bus.i_bus_data;
                    end else if (!wnr_q) begin
                        resp_data = load_extend(bhw_q, addr_q[1:0], bus.i_bus_data);
                    end
                end else if (TIMEOUT_EN && (state_q == ST_WAIT) &&
                             (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d   = ST_RESP;
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    if (TIMEOUT_EN && (state_q == ST_WAIT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Bus qualifiers are held only while the bus cycle is open.
                if (state_d == ST_RESP) begin
                    addr_d  = '0;
                    bhw_d   = '0;
                    wnr_d   = 1'b0;
                    wdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (resp_fire) begin
            if (owner_d) begin
                if_valid_d = 1'b1;
                if_data_d  = resp_data;
                if_err_d   = resp_err;
            end else begin
                ls_valid_d = 1'b1;
                ls_rdata_d = resp_data;
                ls_err_d   = resp_err;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'(FIRST_PRIO);
            owner_q    <= 1'b0;
            addr_q     <= '0;
            bhw_q      <= '0;
            wnr_q      <= 1'b0;
            wdata_q    <= '0;
            bus_dv_q   <= 1'b0;
            cnt_q      <= '0;
            if_valid_q <= 1'b0;
            if_data_q  <= '0;
            if_err_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_rdata_q <= '0;
            ls_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            bhw_q      <= bhw_d;
            wnr_q      <= wnr_d;
            wdata_q    <= wdata_d;
            bus_dv_q   <= bus_dv_d;
            cnt_q      <= cnt_d;
            if_valid_q <= if_valid_d;
            if_data_q  <= if_data_d;
            if_err_q   <= if_err_d;
            ls_valid_q <= ls_valid_d;
            ls_rdata_q <= ls_rdata_d;
            ls_err_q   <= ls_err_d;
        end
    end

    assign bus.o_if_ready      = if_ready_c;
    assign bus.o_if_valid      = if_valid_q;
    assign bus.o_if_data       = if_data_q;
    assign bus.o_if_err        = if_err_q;
    assign bus.o_ls_ready      = ls_ready_c;
    assign bus.o_ls_valid      = ls_valid_q;
    assign bus.o_ls_rdata      = ls_rdata_q;
    assign bus.o_ls_err        = ls_err_q;
    assign bus.o_bus_data      = wdata_q;
    assign bus.o_bus_address   = addr_q;
    assign bus.o_bus_DV        = bus_dv_q;
    assign bus.o_bhw           = bhw_q;
    assign bus.o_write_notread = wnr_q;

endmodule

// File: tb/tb_cpu_bus_interface.sv
// tb_cpu_bus_interface: directed and randomized checks of cpu_bus_interface against a
// transaction-level reference model (arbitration pointer, access legality, lane math).
module tb_cpu_bus_interface;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_bus_interface_if #(.ADDR_W(32)) bif ();

    cpu_bus_interface #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(8),
        .FIRST_PRIO(0)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bif)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          prio_if  = 1'b0;
    bit          last_win_if;
    logic [31:0] last_data;
    logic [31:0] last_bus_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit ls_legal(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
        if (f3 == 3'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        size = access_size(f3);
        off  = int'(a % 4);
        off  = off - (off % size);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = (w >> (8 * off)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [2:0] f3, input logic [31:0] w);
        int size;
        size = access_size(f3);
        if (size == 1) return (w & 32'h0000_00FF) * 32'h0101_0101;
        if (size == 2) return (w & 32'h0000_FFFF) * 32'h0001_0001;
        return w;
    endfunction

    task automatic set_if(input logic [31:0] a);
        bif.i_if_req  = 1'b1;
        bif.i_if_addr = a;
    endtask

    task automatic set_ls(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        bif.i_ls_req    = 1'b1;
        bif.i_ls_we     = we;
        bif.i_ls_funct3 = f3;
        bif.i_ls_addr   = a;
        bif.i_ls_wdata  = wd;
    endtask

    // Called at a negedge in IDLE with requests already driven; ends at the negedge after RESP.
    task automatic run(input logic [31:0] bus_word, input int delay);
        bit          both, win_if, legal, we;
        logic [31:0] a, wd, exp_d, obs_d;
        logic [2:0]  f3;
        #1;
        both   = bif.i_if_req && bif.i_ls_req;
        win_if = bif.i_if_req && (!bif.i_ls_req || prio_if);
        if (both) prio_if = !win_if;
        chk("if_ready", 32'(bif.o_if_ready), 32'(win_if));
        chk("ls_ready", 32'(bif.o_ls_ready), 32'(!win_if));
        if (win_if) begin
            a = bif.i_if_addr; f3 = 3'b010; we = 1'b0; wd = 32'd0; legal = (a % 4) == 0;
        end else begin
            a = bif.i_ls_addr; f3 = bif.i_ls_funct3; we = bif.i_ls_we; wd = bif.i_ls_wdata;
            legal = ls_legal(f3, a);
        end
        last_win_if = win_if;
        @(negedge clk);
        if (win_if) bif.i_if_req = 1'b0;
        else        bif.i_ls_req = 1'b0;
        if (!legal) begin
            exp_d = 32'd0;
            chk("err_no_bus_dv", 32'(bif.o_bus_DV), 32'd0);
        end else begin
            for (int k = 0; k <= delay; k++) begin
                chk("bus_dv", 32'(bif.o_bus_DV), 32'(k == 0));
                chk("bus_addr", bif.o_bus_address, a);
                chk("bhw", 32'(bif.o_bhw), 32'(f3));
                chk("wnr", 32'(bif.o_write_notread), 32'(we));
                if (we) chk("bus_wdata", bif.o_bus_data, exp_store(f3, wd));
                if (k == 0) last_bus_data = bif.o_bus_data;
                chk("early_valid", 32'({bif.o_if_valid, bif.o_ls_valid}), 32'd0);
                chk("busy_ready", 32'({bif.o_if_ready, bif.o_ls_ready}), 32'd0);
                bif.i_bus_DV   = (k == delay);
                bif.i_bus_data = (k == delay) ? bus_word : $urandom;
                @(negedge clk);
            end
            bif.i_bus_DV   = 1'b0;
            bif.i_bus_data = $urandom;
            exp_d = win_if ? bus_word : (we ? 32'd0 : exp_load(f3, a, bus_word));
        end
        obs_d = win_if ? bif.o_if_data : bif.o_ls_rdata;
        chk("resp_valid", 32'({bif.o_if_valid, bif.o_ls_valid}), win_if ? 32'd2 : 32'd1);
        chk("resp_err", 32'(win_if ? bif.o_if_err : bif.o_ls_err), 32'(!legal));
        chk("resp_data", obs_d, exp_d);
        chk("resp_ready", 32'({bif.o_if_ready, bif.o_ls_ready}), 32'd0);
        last_data = obs_d;
        @(negedge clk);
        chk("valid_pulse", 32'({bif.o_if_valid, bif.o_ls_valid}), 32'd0);
        chk("idle_bus_dv", 32'(bif.o_bus_DV), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r, mode;
        bit          we;

        bif.i_if_req = 0; bif.i_if_addr = 0;
        bif.i_ls_req = 0; bif.i_ls_we = 0; bif.i_ls_funct3 = 0; bif.i_ls_addr = 0; bif.i_ls_wdata = 0;
        bif.i_bus_data = 0; bif.i_bus_DV = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'({bif.o_if_ready, bif.o_ls_ready}), 32'd0);
        chk("rst_valid", 32'({bif.o_if_valid, bif.o_ls_valid}), 32'd0);
        chk("rst_err", 32'({bif.o_if_err, bif.o_ls_err}), 32'd0);
        chk("rst_if_data", bif.o_if_data, 32'd0);
        chk("rst_ls_rdata", bif.o_ls_rdata, 32'd0);
        chk("rst_bus_data", bif.o_bus_data, 32'd0);
        chk("rst_bus_addr", bif.o_bus_address, 32'd0);
        chk("rst_bus_ctl", 32'({bif.o_bus_DV, bif.o_bhw, bif.o_write_notread}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Collisions from reset: LS first, then IF; next collision goes to IF
        set_if(32'h300); set_ls(1'b0, 3'b010, 32'h400, 32'd0);
        run(32'h1111_2222, 1);
        chk("t4_first_is_ls", 32'(last_win_if), 32'd0);
        run(32'h3333_4444, 0);
        chk("t4_pending_if", 32'(last_win_if), 32'd1);
        set_if(32'h304); set_ls(1'b1, 3'b010, 32'h408, 32'hCAFE_F00D);
        run(32'd0, 2);
        chk("t4_second_is_if", 32'(last_win_if), 32'd1);
        run(32'd0, 0);
        chk("t4_then_ls", 32'(last_win_if), 32'd0);

        // Fetch with 3-cycle bus latency
        set_if(32'h100);
        run(32'hDEAD_BEEF, 3);
        chk("t1_if_data", last_data, 32'hDEAD_BEEF);

        // Byte loads, signed and unsigned, from lane 3
        set_ls(1'b0, 3'b000, 32'h203, 32'd0);
        run(32'h80FF_0000, 1);
        chk("t2_lb", last_data, 32'hFFFF_FF80);
        set_ls(1'b0, 3'b100, 32'h203, 32'd0);
        run(32'h80FF_0000, 1);
        chk("t2_lbu", last_data, 32'h0000_0080);

        // Halfword store replication
        set_ls(1'b1, 3'b001, 32'h12, 32'h1234_ABCD);
        run($urandom, 2);
        chk("t3_sh_lanes", last_bus_data, 32'hABCD_ABCD);

        // Misaligned word load is rejected without a bus cycle
        set_ls(1'b0, 3'b010, 32'h6, 32'd0);
        run(32'd0, 0);

        // Reset during WAIT abandons the transaction
        set_ls(1'b0, 3'b010, 32'h40, 32'd0);
        #1;
        chk("rw_ready", 32'(bif.o_ls_ready), 32'd1);
        @(negedge clk);
        bif.i_ls_req = 1'b0;
        chk("rw_bus_dv", 32'(bif.o_bus_DV), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_valid", 32'({bif.o_if_valid, bif.o_ls_valid}), 32'd0);
        chk("rw_bus_addr", bif.o_bus_address, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prio_if = 1'b0;
        bif.i_bus_DV   = 1'b1;
        bif.i_bus_data = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge clk);
            chk("rw_late_dv", 32'({bif.o_if_valid, bif.o_ls_valid, bif.o_bus_DV}), 32'd0);
        end
        bif.i_bus_DV = 1'b0;

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            if (mode != 1) begin
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                set_if(a);
            end else begin
                bif.i_if_req = 1'b0;
            end
            if (mode != 0) begin
                r = $urandom_range(0, 9);
                f3 = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 6) ? 3'd2 :
                     (r == 6) ? 3'd4 : (r == 7) ? 3'd5 : (r == 8) ? 3'd3 : 3'd7;
                we = 1'($urandom_range(0, 1));
                if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
                if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
                set_ls(we, f3, a, $urandom);
            end else begin
                bif.i_ls_req = 1'b0;
            end
            run($urandom, $urandom_range(0, 4));
        end
        bif.i_if_req = 1'b0;
        bif.i_ls_req = 1'b0;

        // Bus strobe while idle is ignored
        @(negedge clk);
        bif.i_bus_DV = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_dv_ignored", 32'({bif.o_if_valid, bif.o_ls_valid, bif.o_bus_DV}), 32'd0);
        end
        bif.i_bus_DV = 1'b0;

`ifdef CPU_BIU_TIMEOUT_EN
        // Silent bus: error after 8 WAIT cycles, late strobe ignored
        @(negedge clk);
        set_if(32'h500);
        #1;
        chk("to_ready", 32'(bif.o_if_ready), 32'd1);
        @(negedge clk);
        bif.i_if_req = 1'b0;
        chk("to_bus_dv", 32'(bif.o_bus_DV), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("to_wait", 32'(bif.o_if_valid), 32'd0);
        end
        @(negedge clk);
        chk("to_valid", 32'(bif.o_if_valid), 32'd1);
        chk("to_err", 32'(bif.o_if_err), 32'd1);
        chk("to_data", bif.o_if_data, 32'd0);
        bif.i_bus_DV = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("to_late_dv", 32'({bif.o_if_valid, bif.o_ls_valid}), 32'd0);
        end
        bif.i_bus_DV = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
